// File: rtl/network_if_pkg.sv
// Shared definitions for the network injection path: flit type codes and VC id sizing.
package network_if_pkg;

  localparam logic [1:0] FlitHeader     = 2'd0;
  localparam logic [1:0] FlitPayload    = 2'd1;
  localparam logic [1:0] FlitTail       = 2'd2;
  localparam logic [1:0] FlitHeaderTail = 2'd3;

  // A single virtual network still needs a 1-bit VC id field.
  function automatic int vc_id_width(input int num_vn);
    return (num_vn <= 1) ? 1 : $clog2(num_vn);
  endfunction

endpackage

// File: rtl/nif_sync_fifo.sv
// Single-clock FIFO holding one virtual network's flits; head is always visible.
module nif_sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/network_vn_injector.sv
// Per-VN flit buffering with round-robin injection onto the router channel,
// optionally keeping a packet atomic from header to tail.
module network_vn_injector
  import network_if_pkg::*;
#(
  parameter int NetworkIfFlitWidth               = 64,
  parameter int NetworkIfFlitTypeWidth           = 2,
  parameter int NetworkIfBroadcastWidth          = 1,
  parameter int NetworkIfNumberOfVirtualNetworks = 2,
  parameter int NetworkIfVirtualChannelIdWidth   = vc_id_width(NetworkIfNumberOfVirtualNetworks),
  parameter int FifoDepth                        = 4,
  parameter int PacketLock                       = 0
) (
  input  logic                                                         clk_network_i,
  input  logic                                                         rst_network_ni,
  input  logic [NetworkIfNumberOfVirtualNetworks-1:0]                  in_valid_i,
  output logic [NetworkIfNumberOfVirtualNetworks-1:0]                  in_ready_o,
  input  logic [NetworkIfNumberOfVirtualNetworks*NetworkIfFlitWidth-1:0]     in_flit_i,
  input  logic [NetworkIfNumberOfVirtualNetworks*NetworkIfFlitTypeWidth-1:0] in_flit_type_i,
  input  logic [NetworkIfNumberOfVirtualNetworks*NetworkIfBroadcastWidth-1:0] in_broadcast_i,
  output logic                                                         network_valid_o,
  input  logic [NetworkIfNumberOfVirtualNetworks-1:0]                  network_ready_i,
  output logic [NetworkIfFlitWidth-1:0]                                network_flit_o,
  output logic [NetworkIfFlitTypeWidth-1:0]                            network_flit_type_o,
  output logic [NetworkIfBroadcastWidth-1:0]                           network_broadcast_o,
  output logic [NetworkIfVirtualChannelIdWidth-1:0]                    network_virtual_channel_id_o
);

  localparam int N  = NetworkIfNumberOfVirtualNetworks;
  localparam int FW = NetworkIfFlitWidth;
  localparam int TW = NetworkIfFlitTypeWidth;
  localparam int BW = NetworkIfBroadcastWidth;
  localparam int VW = NetworkIfVirtualChannelIdWidth;
  localparam int EW = FW + TW + BW;

  logic [N-1:0]         full, empty, push, pop, elig;
  logic [N-1:0][EW-1:0] head;
  logic [VW-1:0]        rr_q, rr_d, lock_vn_q, lock_vn_d, gnt_vn, cand;
  logic                 lock_q, lock_d, gnt;
  logic [EW-1:0]        gnt_head;
  logic [TW-1:0]        gnt_type;

  for (genvar v = 0; v < N; v++) begin : g_vn
    assign in_ready_o[v] = rst_network_ni && !full[v];
    assign push[v]       = in_valid_i[v] && in_ready_o[v];
    assign pop[v]        = gnt && (gnt_vn == VW'(v));
    assign elig[v]       = rst_network_ni && !empty[v] && network_ready_i[v] &&
                           ((PacketLock == 0) || !lock_q || (lock_vn_q == VW'(v)));

    nif_sync_fifo #(
      .Width (EW),
      .Depth (FifoDepth)
    ) u_fifo (
      .clk_i   (clk_network_i),
      .rst_ni  (rst_network_ni),
      .push_i  (push[v]),
      .pop_i   (pop[v]),
      .data_i  ({in_flit_i[v*FW +: FW], in_flit_type_i[v*TW +: TW], in_broadcast_i[v*BW +: BW]}),
      .full_o  (full[v]),
      .empty_o (empty[v]),
      .head_o  (head[v])
    );
  end

  // Scan from farthest to nearest so the nearest eligible VN after rr_q wins.
  always_comb begin
    gnt    = 1'b0;
    gnt_vn = '0;
    cand   = '0;
    for (int k = N; k >= 1; k--) begin
      cand = VW'((int'(rr_q) + k) % N);
      if (elig[cand]) begin
        gnt    = 1'b1;
        gnt_vn = cand;
      end
    end
  end

  assign gnt_head = head[gnt_vn];
  assign gnt_type = gnt_head[BW +: TW];

  assign network_valid_o              = gnt;
  assign {network_flit_o, network_flit_type_o, network_broadcast_o} = gnt ? gnt_head : '0;
  assign network_virtual_channel_id_o = gnt ? gnt_vn : '0;

  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_vn_d = lock_vn_q;
    if (gnt) begin
      rr_d = gnt_vn;
      if (PacketLock != 0) begin
        if (gnt_type == TW'(FlitHeader)) begin
          lock_d    = 1'b1;
          lock_vn_d = gnt_vn;
        end else if (gnt_type == TW'(FlitTail)) begin
          lock_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_network_i) begin
    if (!rst_network_ni) begin
      rr_q      <= VW'(N - 1);
      lock_q    <= 1'b0;
      lock_vn_q <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_vn_q <= lock_vn_d;
    end
  end

endmodule

// File: tb/tb_network_vn_injector.sv
// Drives interleaved and packet-locked injectors with identical stimulus and
// compares both against queue-based reference models.
module tb_network_vn_injector;
  import network_if_pkg::*;

  localparam int N  = 2;
  localparam int FW = 64;
  localparam int TW = 2;
  localparam int BW = 1;
  localparam int D  = 4;
  localparam int EW = FW + TW + BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [N-1:0]        in_valid, net_ready;
  logic [N*FW-1:0]     in_flit;
  logic [N*TW-1:0]     in_type;
  logic [N*BW-1:0]     in_bc;
  logic [N-1:0]        rdy [2];
  logic                nv  [2];
  logic [FW-1:0]       nf  [2];
  logic [TW-1:0]       nt  [2];
  logic [BW-1:0]       nb  [2];
  logic [0:0]          nvc [2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    network_vn_injector #(
      .NetworkIfFlitWidth               (FW),
      .NetworkIfFlitTypeWidth           (TW),
      .NetworkIfBroadcastWidth          (BW),
      .NetworkIfNumberOfVirtualNetworks (N),
      .NetworkIfVirtualChannelIdWidth   (1),
      .FifoDepth                        (D),
      .PacketLock                       (m)
    ) u_dut (
      .clk_network_i                (clk),
      .rst_network_ni               (rst_n),
      .in_valid_i                   (in_valid),
      .in_ready_o                   (rdy[m]),
      .in_flit_i                    (in_flit),
      .in_flit_type_i               (in_type),
      .in_broadcast_i               (in_bc),
      .network_valid_o              (nv[m]),
      .network_ready_i              (net_ready),
      .network_flit_o               (nf[m]),
      .network_flit_type_o          (nt[m]),
      .network_broadcast_o          (nb[m]),
      .network_virtual_channel_id_o (nvc[m])
    );
  end

  // Reference state per instance (instance m runs with PacketLock = m).
  logic [EW-1:0] mq [2][N][$];
  int            rr  [2];
  bit            lk  [2];
  int            lvn [2];
  int            errs   = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input logic [N-1:0] vl, input logic [N-1:0] rd,
                      input logic [1:0] t0, input logic [1:0] t1);
    @(negedge clk);
    rst_n     = r;
    in_valid  = vl;
    net_ready = rd;
    in_flit   = {$urandom, $urandom, $urandom, $urandom};
    in_type   = {t1, t0};
    in_bc     = 2'($urandom);
    #1;
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0]  er;
      bit            g;
      int            gv;
      logic [EW-1:0] hd;
      er = '0;
      for (int v = 0; v < N; v++)
        if (r && mq[m][v].size() < D) er[v] = 1'b1;
      g  = 0;
      gv = 0;
      hd = '0;
      if (r) begin
        for (int k = 1; k <= N; k++) begin
          int v;
          v = (rr[m] + k) % N;
          if (!g && mq[m][v].size() > 0 && rd[v] && (m == 0 || !lk[m] || lvn[m] == v)) begin
            g  = 1;
            gv = v;
          end
        end
      end
      if (g) hd = mq[m][gv][0];
      chk($sformatf("in_ready[lock=%0d]", m), 128'(rdy[m]), 128'(er));
      chk($sformatf("valid[lock=%0d]", m), 128'(nv[m]), 128'(g));
      chk($sformatf("out[lock=%0d]", m), 128'({nf[m], nt[m], nb[m], nvc[m]}),
          g ? 128'({hd, 1'(gv)}) : 128'(0));

      if (!r) begin
        for (int v = 0; v < N; v++) mq[m][v].delete();
        rr[m]  = N - 1;
        lk[m]  = 0;
        lvn[m] = 0;
      end else begin
        if (g) begin
          void'(mq[m][gv].pop_front());
          rr[m] = gv;
          if (m == 1) begin
            if (hd[BW +: TW] == FlitHeader) begin
              lk[m]  = 1;
              lvn[m] = gv;
            end else if (hd[BW +: TW] == FlitTail) begin
              lk[m] = 0;
            end
          end
        end
        for (int v = 0; v < N; v++)
          if (vl[v] && er[v])
            mq[m][v].push_back({in_flit[v*FW +: FW], in_type[v*TW +: TW], in_bc[v]});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; net_ready = '0; in_flit = '0; in_type = '0; in_bc = '0;
    for (int m = 0; m < 2; m++) begin rr[m] = N - 1; lk[m] = 0; lvn[m] = 0; end

    // Reset, then simultaneous header_tail on both VNs.
    repeat (2) step(0, 2'b00, 2'b00, 0, 0);
    step(1, 2'b11, 2'b11, FlitHeaderTail, FlitHeaderTail);
    repeat (3) step(1, 2'b00, 2'b11, 0, 0);

    // Overfill VN0 while the router stalls, then drain.
    repeat (6) step(1, 2'b01, 2'b00, FlitHeaderTail, 0);
    for (int i = 0; i < 7; i++) step(1, (i < 2) ? 2'b01 : 2'b00, 2'b01, FlitHeaderTail, 0);

    // VN0 packet with a gap before its payload; VN1 single-flit packet competing.
    step(0, 2'b00, 2'b00, 0, 0);
    step(1, 2'b11, 2'b11, FlitHeader, FlitHeaderTail);
    repeat (2) step(1, 2'b00, 2'b11, 0, 0);
    step(1, 2'b01, 2'b11, FlitPayload, 0);
    step(1, 2'b01, 2'b11, FlitTail, 0);
    repeat (4) step(1, 2'b00, 2'b11, 0, 0);

    // Ready toggling on VC0 with three queued flits.
    repeat (3) step(1, 2'b01, 2'b00, FlitHeaderTail, 0);
    step(1, 2'b00, 2'b01, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0);
    step(1, 2'b00, 2'b01, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0);
    repeat (2) step(1, 2'b00, 2'b01, 0, 0);

    // Reset mid-packet with flits queued.
    step(1, 2'b01, 2'b00, FlitHeader, 0);
    repeat (2) step(1, 2'b01, 2'b00, FlitPayload, 0);
    step(0, 2'b01, 2'b01, FlitPayload, 0);
    step(1, 2'b00, 2'b01, 0, 0);
    step(1, 2'b01, 2'b01, FlitHeaderTail, 0);
    step(1, 2'b00, 2'b01, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) != 0, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
